// File: rtl/liteic_slave_node_read_pkg.sv
// liteic_slave_node_read_pkg: crossbar sizing constants, read-node state type and pointer helper
package liteic_slave_node_read_pkg;
    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_ARADDR_WIDTH = 20;
    localparam int IC_RDATA_WIDTH = 32;
    localparam int IC_RRESP_WIDTH = 2;
    localparam logic [IC_NUM_MASTER_SLOTS-1:0] IC_RD_CONNECTIVITY = 4'b1111;
    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_RWAIT, ST_RESP} rd_node_state_t;
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/liteic_slave_node_read_if.sv
// liteic_slave_node_read_if: AXI-Lite read channels (AR/R) between a node (master) and a slave port
//   ar_addr/ar_valid/r_ready driven by master; ar_ready/r_data/r_resp/r_valid driven by slave
interface liteic_slave_node_read_if
    import liteic_slave_node_read_pkg::*;
#(
    parameter int AW = IC_ARADDR_WIDTH - 12,
    parameter int DW = IC_RDATA_WIDTH,
    parameter int RW = IC_RRESP_WIDTH
);
    logic [AW-1:0] ar_addr;
    logic          ar_valid;
    logic          ar_ready;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_resp;
    logic          r_valid;
    logic          r_ready;
    modport master(output ar_addr, ar_valid, r_ready, input ar_ready, r_data, r_resp, r_valid);
    modport slave(input ar_addr, ar_valid, r_ready, output ar_ready, r_data, r_resp, r_valid);
endinterface

// File: rtl/liteic_slave_node_read_rr_arbiter.sv
// liteic_rr_arbiter: combinational round-robin pick of the first request at/after ptr_i
//   req_i  : request vector
//   ptr_i  : priority pointer (index searched first)
//   grant_o: one-hot winner (zero when no request)
//   idx_o  : winner index (zero when no request)
module liteic_rr_arbiter #(
    parameter int N = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);
    // Scan from the farthest slot back to the pointer so the nearest requester is written last.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
        end
        grant_o = (|req_i) ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/liteic_slave_node_read.sv
// liteic_slave_node_read: read-path crossbar node, round-robin AR arbitration onto one AXI-Lite slave
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   slv_axil             : AR/R channels towards the slave
//   cbar_ar_reqst_*      : per-master AR address/valid/ready
//   cbar_resp_*          : shared {r_resp, r_data}, per-master R valid/ready
module liteic_slave_node_read
    import liteic_slave_node_read_pkg::*;
#(
    parameter int NUM_MST = IC_NUM_MASTER_SLOTS,
    parameter int AR_W = IC_ARADDR_WIDTH - 12,
    parameter int RD_W = IC_RDATA_WIDTH,
    parameter int RR_W = IC_RRESP_WIDTH,
    parameter logic [NUM_MST-1:0] CONN = IC_RD_CONNECTIVITY
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    liteic_slave_node_read_if.master       slv_axil,
    input  logic [NUM_MST-1:0][AR_W-1:0]   cbar_ar_reqst_data_i,
    input  logic [NUM_MST-1:0]             cbar_ar_reqst_val_i,
    output logic [NUM_MST-1:0]             cbar_ar_reqst_rdy_o,
    output logic [RD_W+RR_W-1:0]           cbar_resp_data_o,
    output logic [NUM_MST-1:0]             cbar_resp_val_o,
    input  logic [NUM_MST-1:0]             cbar_resp_rdy_i
);
    localparam int IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    rd_node_state_t        state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, idx_q, idx_d, arb_idx;
    logic [NUM_MST-1:0]    grant_q, grant_d, arb_grant;
    logic [AR_W-1:0]       addr_q, addr_d;
    logic [RD_W+RR_W-1:0]  buf_q, buf_d;
    // Unconnected slots are masked out before arbitration so they can never win.
    liteic_rr_arbiter #(.N(NUM_MST), .IW(IW)) u_arb (
        .req_i  (cbar_ar_reqst_val_i & CONN),
        .ptr_i  (ptr_q),
        .grant_o(arb_grant),
        .idx_o  (arb_idx)
    );
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: if (|arb_grant) begin
                state_d = ST_AR;
                grant_d = arb_grant;
                idx_d   = arb_idx;
                addr_d  = cbar_ar_reqst_data_i[arb_idx];
            end
            ST_AR: if (slv_axil.ar_ready) state_d = ST_RWAIT;
            ST_RWAIT: if (slv_axil.r_valid) begin
                state_d = ST_RESP;
                buf_d   = {slv_axil.r_resp, slv_axil.r_data};
            end
            default: if (|(cbar_resp_rdy_i & grant_q)) begin
                state_d = ST_IDLE;
                ptr_d   = IW'(wrap_inc(int'(idx_q), NUM_MST));
            end
        endcase
    end
    // The IDLE grant is combinational from the request inputs, so it is gated by reset explicitly.
    assign cbar_ar_reqst_rdy_o = (rstn_i && state_q == ST_IDLE) ? arb_grant : '0;
    assign cbar_resp_val_o     = (state_q == ST_RESP) ? grant_q : '0;
    assign cbar_resp_data_o    = buf_q;
    assign slv_axil.ar_valid   = state_q == ST_AR;
    assign slv_axil.ar_addr    = addr_q;
    assign slv_axil.r_ready    = state_q == ST_RWAIT;
endmodule
